// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the memory responder's state and owner encodings.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  // Responder FSM: wait for a request, run the RAM access, pulse the hit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_resp_state_t;

  // Which requester currently owns the RAM.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_grant_arb.sv
// Grant decision for the shared RAM: data wins over instruction unless the
// instruction side has already watched MAX_DSTREAK data grants go by.
module mem_grant_arb
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int STREAK_W    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arb_en_i,   // responder is idle and able to start an access
  input  logic       ireq_i,     // instruction read pending
  input  logic       dreq_i,     // data read or write pending
  output logic       grant_o,    // start an access this cycle
  output mem_owner_t owner_o     // who gets it
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                d_allowed;

  // Data may go if nobody else waits, or the waiting instruction has not yet been passed over too often.
  assign d_allowed = dreq_i && (!ireq_i || (streak_q < STREAK_MAX));

  // Priority decision, only meaningful while the responder is idle.
  always_comb begin
    grant_o = 1'b0;
    owner_o = OWN_I;
    if (arb_en_i) begin
      if (d_allowed) begin
        grant_o = 1'b1;
        owner_o = OWN_D;
      end else if (ireq_i) begin
        grant_o = 1'b1;
        owner_o = OWN_I;
      end
    end
  end

  // Streak bookkeeping: count data grants that bypass a waiting instruction, clear otherwise.
  always_comb begin
    streak_d = streak_q;
    if (grant_o) begin
      if ((owner_o == OWN_D) && ireq_i) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serialises instruction and data requests onto one
// single-port RAM and returns one-cycle ihit/dhit pulses with load data.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int STREAK_W    = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] imemload,
  output logic [WORD_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
);

  mem_resp_state_t   state_q;
  mem_owner_t        owner_q;
  logic              wr_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] store_q;
  logic              ramren_q;
  logic              ramwen_q;
  logic              ihit_q;
  logic              dhit_q;
  logic [WORD_W-1:0] iload_q;
  logic [WORD_W-1:0] dload_q;

  logic              grant;
  mem_owner_t        grant_owner;

  mem_grant_arb #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .STREAK_W    (STREAK_W)
  ) u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .arb_en_i (state_q == IDLE),
    .ireq_i   (imemREN),
    .dreq_i   (dmemREN | dmemWEN),
    .grant_o  (grant),
    .owner_o  (grant_owner)
  );

  // Responder FSM; strobes and hits are registered so they change only on edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      ramren_q <= 1'b0;
      ramwen_q <= 1'b0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= grant_owner;
            state_q <= ACCESS;
            if (grant_owner == OWN_D) begin
              // A simultaneous read+write request is treated as a write.
              addr_q   <= dmemaddr;
              store_q  <= dmemstore;
              wr_q     <= dmemWEN;
              ramwen_q <= dmemWEN;
              ramren_q <= ~dmemWEN;
            end else begin
              addr_q   <= imemaddr;
              store_q  <= '0;
              wr_q     <= 1'b0;
              ramwen_q <= 1'b0;
              ramren_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // The RAM cannot be aborted, so wait as long as it takes.
          if (ramready) begin
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            state_q  <= RESP;
            if (owner_q == OWN_D) begin
              dhit_q <= 1'b1;
              if (!wr_q) begin
                dload_q <= ramload;
              end
            end else begin
              ihit_q  <= 1'b1;
              iload_q <= ramload;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          ramren_q <= 1'b0;
          ramwen_q <= 1'b0;
        end
      endcase
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = iload_q;
  assign dmemload = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, read, write with waits, contention,
// anti-starvation cadence, read+write collision and reset during an access.
module tb_mem_responder;

  logic        clk;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int tests_run;
  int tests_failed;

  mem_responder #(
    .WORD_W      (32),
    .MAX_DSTREAK (4),
    .STREAK_W    (3)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ihit      (ihit),
    .dhit      (dhit),
    .imemload  (imemload),
    .dmemload  (dmemload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramready  (ramready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    imemaddr = 32'h0; dmemaddr = 32'h0; dmemstore = 32'h0;
    ramload = 32'h0; ramready = 1'b0;
    tick(); tick();
    tests_run++; if (ihit !== 1'b0) begin tests_failed++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    tests_run++; if (dhit !== 1'b0) begin tests_failed++; $display("FAIL reset_dhit: got %b want 0", dhit); end
    tests_run++; if ({ramREN, ramWEN} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {ramREN, ramWEN}); end
    tests_run++; if (ramaddr !== 32'h0) begin tests_failed++; $display("FAIL reset_ramaddr: got %h want 0", ramaddr); end
    tests_run++; if ({imemload, dmemload} !== 64'h0) begin tests_failed++; $display("FAIL reset_loads: got %h/%h want 0/0", imemload, dmemload); end
    RST = 1'b0;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_single_read();
    dmemREN = 1'b1; dmemaddr = 32'h40;                      // cycle 0
    tick();                                                 // cycle 1
    tests_run++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin tests_failed++; $display("FAIL read_strobe: got ren=%b wen=%b want 1/0", ramREN, ramWEN); end
    tests_run++; if (ramaddr !== 32'h40) begin tests_failed++; $display("FAIL read_addr: got %h want 00000040", ramaddr); end
    tests_run++; if (ihit !== 1'b0 || dhit !== 1'b0) begin tests_failed++; $display("FAIL read_early_hit: got i=%b d=%b want 0/0", ihit, dhit); end
    ramready = 1'b1; ramload = 32'hDEADBEEF;
    tick();                                                 // cycle 2
    tests_run++; if (dhit !== 1'b1 || ihit !== 1'b0) begin tests_failed++; $display("FAIL read_dhit: got d=%b i=%b want 1/0", dhit, ihit); end
    tests_run++; if (dmemload !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_data: got %h want deadbeef", dmemload); end
    tests_run++; if (ramREN !== 1'b0) begin tests_failed++; $display("FAIL read_resp_strobe: got %b want 0", ramREN); end
    dmemREN = 1'b0; ramready = 1'b0; ramload = 32'h0;
    tick();                                                 // cycle 3
    tests_run++; if (dhit !== 1'b0) begin tests_failed++; $display("FAIL read_pulse_width: got %b want 0", dhit); end
    $display("[TB] read addr=00000040 data=%h", dmemload);
  endtask

  task automatic test_write();
    dmemWEN = 1'b1; dmemaddr = 32'h80; dmemstore = 32'h12345678;   // cycle 0
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests_run++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin tests_failed++; $display("FAIL write_strobe_c%0d: got wen=%b ren=%b want 1/0", c, ramWEN, ramREN); end
      tests_run++; if (ramstore !== 32'h12345678 || ramaddr !== 32'h80) begin tests_failed++; $display("FAIL write_bus_c%0d: got addr=%h store=%h want 00000080/12345678", c, ramaddr, ramstore); end
      tests_run++; if (dhit !== 1'b0) begin tests_failed++; $display("FAIL write_early_hit_c%0d: got %b want 0", c, dhit); end
      if (c == 4) begin ramready = 1'b1; ramload = 32'h55555555; end
    end
    tick();                                                 // cycle 5
    tests_run++; if (dhit !== 1'b1) begin tests_failed++; $display("FAIL write_dhit: got %b want 1", dhit); end
    tests_run++; if (dmemload !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL write_load_kept: got %h want deadbeef", dmemload); end
    dmemWEN = 1'b0; ramready = 1'b0;
    tick();
    $display("[TB] write addr=00000080 data=12345678");
  endtask

  task automatic test_contention();
    imemREN = 1'b1; imemaddr = 32'h100; dmemREN = 1'b1; dmemaddr = 32'h44;  // cycle 0
    tick();                                                 // cycle 1
    tests_run++; if (ramaddr !== 32'h44 || ramREN !== 1'b1) begin tests_failed++; $display("FAIL cont_data_first: got addr=%h ren=%b want 00000044/1", ramaddr, ramREN); end
    ramready = 1'b1; ramload = 32'hAAAA0001;
    tick();                                                 // cycle 2
    tests_run++; if (dhit !== 1'b1 || ihit !== 1'b0) begin tests_failed++; $display("FAIL cont_dhit: got d=%b i=%b want 1/0", dhit, ihit); end
    dmemREN = 1'b0; ramready = 1'b0;
    tick();                                                 // cycle 3, IDLE
    tick();                                                 // cycle 4
    tests_run++; if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin tests_failed++; $display("FAIL cont_instr_second: got addr=%h ren=%b want 00000100/1", ramaddr, ramREN); end
    ramready = 1'b1; ramload = 32'h0BADF00D;
    tick();                                                 // cycle 5
    tests_run++; if (ihit !== 1'b1 || dhit !== 1'b0) begin tests_failed++; $display("FAIL cont_ihit: got i=%b d=%b want 1/0", ihit, dhit); end
    tests_run++; if (imemload !== 32'h0BADF00D) begin tests_failed++; $display("FAIL cont_iload: got %h want 0badf00d", imemload); end
    imemREN = 1'b0; ramready = 1'b0;
    tick();
    $display("[TB] contention data then instr=%h", imemload);
  endtask

  // Both requesters always asking; the RAM answers in the first ACCESS cycle.
  task automatic test_starvation();
    string expect_seq;
    string got_seq;
    int    hits;
    expect_seq = "DDDDID";
    got_seq    = "";
    hits       = 0;
    imemREN = 1'b1; imemaddr = 32'h300; dmemREN = 1'b1; dmemaddr = 32'h200;
    for (int c = 0; c < 40 && hits < 6; c++) begin
      tests_run++; if (ihit && dhit) begin tests_failed++; $display("FAIL starve_both_hits: got i=1 d=1 at cycle %0d", c); end
      if (ihit || dhit) begin
        tests_run++; if (c !== 2 + 3 * hits) begin tests_failed++; $display("FAIL starve_cadence_%0d: got cycle %0d want %0d", hits, c, 2 + 3 * hits); end
        if (dhit) begin
          got_seq = {got_seq, "D"};
          tests_run++; if (dmemload !== 32'h5A5A0200) begin tests_failed++; $display("FAIL starve_dload_%0d: got %h want 5a5a0200", hits, dmemload); end
        end else begin
          got_seq = {got_seq, "I"};
          tests_run++; if (imemload !== 32'h5A5A0300) begin tests_failed++; $display("FAIL starve_iload_%0d: got %h want 5a5a0300", hits, imemload); end
        end
        hits++;
      end
      ramready = ramREN | ramWEN;
      ramload  = ramaddr ^ 32'h5A5A0000;
      if (hits < 6) tick();
    end
    tests_run++; if (got_seq != expect_seq) begin tests_failed++; $display("FAIL starve_order: got %s want %s", got_seq, expect_seq); end
    imemREN = 1'b0; dmemREN = 1'b0; ramready = 1'b0;
    tick();
    $display("[TB] starvation hit order %s", got_seq);
  endtask

  task automatic test_read_write_both();
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h90; dmemstore = 32'hCAFEF00D;
    tick();                                                 // cycle 1
    tests_run++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin tests_failed++; $display("FAIL rw_strobes: got wen=%b ren=%b want 1/0", ramWEN, ramREN); end
    ramready = 1'b1; ramload = 32'hFFFFFFFF;
    tick();                                                 // cycle 2
    tests_run++; if (dhit !== 1'b1) begin tests_failed++; $display("FAIL rw_dhit: got %b want 1", dhit); end
    tests_run++; if (dmemload !== 32'h5A5A0200) begin tests_failed++; $display("FAIL rw_load_kept: got %h want 5a5a0200", dmemload); end
    dmemREN = 1'b0; dmemWEN = 1'b0; ramready = 1'b0;
    tick();                                                 // cycle 3
    tests_run++; if (dhit !== 1'b0) begin tests_failed++; $display("FAIL rw_single_pulse: got %b want 0", dhit); end
    $display("[TB] read+write collision addr=00000090 store=cafef00d");
  endtask

  task automatic test_reset_mid_access();
    dmemREN = 1'b1; dmemaddr = 32'h60;                      // cycle 0
    tick();                                                 // cycle 1
    tests_run++; if (ramREN !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_setup: got %b want 1", ramREN); end
    RST = 1'b1;
    tick();                                                 // cycle 2
    tests_run++; if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin tests_failed++; $display("FAIL rst_mid_outputs: got %b want 0000", {ramREN, ramWEN, ihit, dhit}); end
    tests_run++; if (ramaddr !== 32'h0 || dmemload !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_regs: got addr=%h load=%h want 0/0", ramaddr, dmemload); end
    RST = 1'b0;
    tick();                                                 // cycle 3
    tests_run++; if (ramREN !== 1'b1 || ramaddr !== 32'h60) begin tests_failed++; $display("FAIL rst_mid_retry: got ren=%b addr=%h want 1/00000060", ramREN, ramaddr); end
    ramready = 1'b1; ramload = 32'h600D600D;
    tick();                                                 // cycle 4
    tests_run++; if (dhit !== 1'b1 || dmemload !== 32'h600D600D) begin tests_failed++; $display("FAIL rst_mid_done: got dhit=%b load=%h want 1/600d600d", dhit, dmemload); end
    dmemREN = 1'b0; ramready = 1'b0;
    tick();
    $display("[TB] reset mid-access then retry data=%h", dmemload);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_starvation();
    test_read_write_both();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
